// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video fetcher, the Z80 core, the VRAM and the arbiter.
interface vram_arbiter_if;
    // video side
    logic        vid_read;
    logic        vid_busy;
    logic [12:0] vid_a;
    logic [7:0]  vid_d;
    // CPU side
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_ce;
    // VRAM side
    logic [13:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic        ram_we;

    // Arbiter view
    modport slave (
        input  vid_read, vid_busy, vid_a,
        input  cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_a, cpu_do,
        input  ram_q,
        output vid_d, cpu_di, cpu_ce, ram_a, ram_d, ram_we
    );

    // Environment view (video, CPU and RAM models)
    modport master (
        output vid_read, vid_busy, vid_a,
        output cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_a, cpu_do,
        output ram_q,
        input  vid_d, cpu_di, cpu_ce, ram_a, ram_d, ram_we
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the 16K screen RAM between video fetches and the Z80, and produces the
// CPU clock enable with Spectrum-style contention. All state changes on the falling
// clock edge so the rising edge stays free for the video block.
module vram_arbiter #(
    parameter int unsigned CE_DIV    = 2,
    parameter logic [1:0]  CONT_BANK = 2'b01
) (
    input  logic           clock,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);

    localparam int unsigned CntW   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CE_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StHold
    } state_e;

    state_e          state;
    logic [CntW-1:0] ce_cnt;
    logic [7:0]      cpu_di_q;

    logic cont_sel;
    logic vram_req;
    logic contend;
    logic grant;

    assign cont_sel = !bus.cpu_mreq_n && (bus.cpu_a[15:14] == CONT_BANK);
    assign vram_req = cont_sel && (!bus.cpu_rd_n || !bus.cpu_wr_n);
    assign contend  = !bus.vid_busy && (cont_sel || (!bus.cpu_iorq_n && !bus.cpu_a[0]));

    // Video always wins; an aborted request (strobes gone) never reaches the RAM.
    assign grant    = (state == StPend) && !bus.vid_read && vram_req;

    assign bus.cpu_ce = (ce_cnt == CntMax) && !contend && (state != StPend);
    assign bus.ram_we = grant && !bus.cpu_wr_n;
    assign bus.ram_a  = grant ? bus.cpu_a[13:0] : {1'b0, bus.vid_a};
    assign bus.ram_d  = bus.cpu_do;
    assign bus.vid_d  = bus.ram_q;
    assign bus.cpu_di = cpu_di_q;

    // Free-running divider; suppressed enables are dropped so CPU phase tracks video.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            ce_cnt <= '0;
        end else if (ce_cnt == CntMax) begin
            ce_cnt <= '0;
        end else begin
            ce_cnt <= ce_cnt + 1'b1;
        end
    end

    // One RAM access per CPU request; HOLD blocks a second write in the same Z80 cycle.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            cpu_di_q <= 8'h00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (vram_req) begin
                        state <= StPend;
                    end
                end
                StPend: begin
                    if (!vram_req) begin
                        state <= StIdle;
                    end else if (grant) begin
                        if (!bus.cpu_rd_n) begin
                            cpu_di_q <= bus.ram_q;
                        end
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (!vram_req) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;

    localparam int unsigned CeDiv = 2;

    logic clock;
    logic reset;

    vram_arbiter_if bus();

    vram_arbiter #(
        .CE_DIV    (CeDiv),
        .CONT_BANK (2'b01)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // VRAM written by the DUT, and the image the model expects
    logic [7:0] vram      [16384];
    logic [7:0] model_mem [16384];

    assign bus.ram_q = vram[bus.ram_a];

    always @(negedge clock) begin
        if (bus.ram_we) vram[bus.ram_a] <= bus.ram_d;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int ce_seen = 0;
    int we_seen = 0;
    logic [13:0] last_we_a = '0;
    logic [7:0]  last_we_d = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt  = 0;     // falling edges since reset, modulo CeDiv
    logic       m_wait = 1'b0;  // CPU request seen, RAM access not yet made
    logic       m_done = 1'b0;  // access made, waiting for the Z80 to end its cycle
    logic [7:0] m_di   = 8'h00;

    function automatic logic f_vreq();
        return !bus.cpu_mreq_n && bus.cpu_a[15:14] == 2'b01 && (!bus.cpu_rd_n || !bus.cpu_wr_n);
    endfunction

    function automatic logic f_cont();
        return !bus.vid_busy && ((!bus.cpu_mreq_n && bus.cpu_a[15:14] == 2'b01) ||
                                 (!bus.cpu_iorq_n && !bus.cpu_a[0]));
    endfunction

    function automatic logic f_grant();
        return m_wait && !bus.vid_read && f_vreq();
    endfunction

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_wait <= 1'b0;
            m_done <= 1'b0;
            m_di   <= 8'h00;
        end else begin
            m_cnt <= (m_cnt + 1) % CeDiv;
            if (f_grant() && !bus.cpu_rd_n) m_di <= model_mem[bus.cpu_a[13:0]];
            if (f_grant() && !bus.cpu_wr_n) model_mem[bus.cpu_a[13:0]] <= bus.cpu_do;
            if (m_wait) begin
                if (!f_vreq()) m_wait <= 1'b0;
                else if (f_grant()) begin
                    m_wait <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (m_done) begin
                if (!f_vreq()) m_done <= 1'b0;
            end else if (f_vreq()) begin
                m_wait <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clock) begin : compare
        logic        eg;
        logic [13:0] ea;
        eg = f_grant();
        ea = eg ? bus.cpu_a[13:0] : {1'b0, bus.vid_a};
        chk("cpu_ce", int'(bus.cpu_ce), int'((m_cnt == CeDiv - 1) && !f_cont() && !m_wait));
        chk("ram_we", int'(bus.ram_we), int'(eg && !bus.cpu_wr_n));
        chk("ram_a", int'(bus.ram_a), int'(ea));
        chk("ram_d", int'(bus.ram_d), int'(bus.cpu_do));
        chk("vid_d", int'(bus.vid_d), int'(vram[ea]));
        chk("cpu_di", int'(bus.cpu_di), int'(m_di));
        if (bus.cpu_ce) ce_seen++;
        if (bus.ram_we) begin
            we_seen++;
            last_we_a = bus.ram_a;
            last_we_d = bus.ram_d;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic bus_idle();
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        bus.cpu_wr_n   = 1'b1;
        bus.vid_read   = 1'b0;
        bus.vid_busy   = 1'b1;
    endtask

    task automatic set_mem(input int a, input logic [7:0] d);
        vram[a]      = d;
        model_mem[a] = d;
    endtask

    initial begin
        int mism;
        int hold;
        for (int i = 0; i < 16384; i++) set_mem(i, 8'($urandom));
        bus_idle();
        bus.vid_a  = '0;
        bus.cpu_a  = '0;
        bus.cpu_do = '0;
        reset = 1'b1;
        #1;
        chk("reset_ram_we", int'(bus.ram_we), 0);
        chk("reset_cpu_ce", int'(bus.cpu_ce), 0);
        chk("reset_cpu_di", int'(bus.cpu_di), 0);
        cyc(3);
        reset = 1'b0;

        // 1: free-running divider, no RAM writes
        ce_seen = 0;
        we_seen = 0;
        cyc(10);
        chk("idle_ce_count", ce_seen, 5);
        chk("idle_we_count", we_seen, 0);

        // 2: CPU write 0x4000 <- 0xA5
        set_mem(0, 8'h00);
        we_seen = 0;
        bus.cpu_a = 16'h4000; bus.cpu_do = 8'hA5;
        bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
        cyc(4);
        bus_idle();
        cyc(2);
        chk("wr_we_count", we_seen, 1);
        chk("wr_ram_a", int'(last_we_a), 0);
        chk("wr_ram_d", int'(last_we_d), 8'hA5);
        chk("wr_mem", int'(vram[0]), 8'hA5);

        // 3: read 0x5800, video fetch on the first PEND cycle
        set_mem(14'h1800, 8'h3C);
        bus.vid_a = 13'h0123;
        bus.cpu_a = 16'h5800; bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0;
        cyc(1);
        bus.vid_read = 1'b1;
        cyc(1);
        bus.vid_read = 1'b0;
        cyc(3);
        bus_idle();
        cyc(1);
        chk("rd_cpu_di", int'(bus.cpu_di), 8'h3C);

        // 4: contended mreq with no strobe while the display fetch runs
        ce_seen = 0;
        bus.cpu_a = 16'h4000; bus.cpu_mreq_n = 1'b0; bus.vid_busy = 1'b0;
        cyc(6);
        chk("cont_ce_count", ce_seen, 0);
        ce_seen = 0;
        bus.vid_busy = 1'b1;
        cyc(2);
        chk("cont_resume_ce", ce_seen, 1);
        bus_idle();

        // 5: even I/O port stalls, odd port does not
        ce_seen = 0;
        we_seen = 0;
        bus.cpu_a = 16'h00FE; bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.vid_busy = 1'b0;
        cyc(6);
        chk("io_even_ce", ce_seen, 0);
        ce_seen = 0;
        bus.cpu_a = 16'h00FF;
        cyc(6);
        chk("io_odd_ce", ce_seen, 3);
        chk("io_we_count", we_seen, 0);
        bus_idle();

        // 6: reset while a write waits in PEND
        set_mem(1, 8'h5A);
        cyc(1);
        bus.vid_read = 1'b1;
        bus.cpu_a = 16'h4001; bus.cpu_do = 8'hC3;
        bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
        cyc(3);
        we_seen = 0;
        reset = 1'b1;
        #1;
        chk("rst_pend_we", int'(bus.ram_we), 0);
        chk("rst_pend_di", int'(bus.cpu_di), 0);
        bus.vid_read = 1'b0;
        cyc(2);
        bus_idle();
        cyc(1);
        reset = 1'b0;
        cyc(4);
        chk("rst_no_write", we_seen, 0);
        chk("rst_mem_kept", int'(vram[1]), 8'h5A);

        // randomized traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                int kind;
                hold = $urandom_range(1, 5);
                bus.cpu_mreq_n = 1'b1; bus.cpu_iorq_n = 1'b1;
                bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1;
                bus.cpu_a  = 16'($urandom);
                bus.cpu_do = 8'($urandom);
                kind = $urandom_range(0, 9);
                if (kind < 6) begin
                    if ($urandom_range(0, 1) == 1) bus.cpu_a[15:14] = 2'b01;
                    bus.cpu_mreq_n = 1'b0;
                    if (kind < 3) bus.cpu_rd_n = 1'b0;
                    else if (kind < 5) bus.cpu_wr_n = 1'b0;
                end else if (kind < 8) begin
                    bus.cpu_iorq_n = 1'b0;
                    bus.cpu_rd_n = 1'b0;
                end
            end
            hold--;
            bus.vid_read = ($urandom_range(0, 9) < 3);
            bus.vid_a    = 13'($urandom);
            if ($urandom_range(0, 9) == 0) bus.vid_busy = ~bus.vid_busy;
            if (c == 1500) begin
                reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end
            cyc(1);
        end
        bus_idle();
        cyc(3);

        mism = 0;
        for (int i = 0; i < 16384; i++) if (vram[i] !== model_mem[i]) mism++;
        chk("mem_image_mismatches", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
